instruction_controller: RTL

INSTRUCTION_CONTROLLER -- requirements
Module: instruction_controller

---
 rtl/instruction_controller_pkg.sv | 39 +++
 rtl/instr_decoder.sv | 49 ++++
 rtl/instruction_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instruction_controller_pkg.sv
// Shared encodings for the instruction controller and its datapath:
// FSM states, opcode/op fields, decoded instruction classes and ALU operations.
package instruction_controller_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_ALU       = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    // Decoded instruction class; zero means the opcode is not supported.
    localparam logic [2:0] CLS_ILLEGAL = 3'd0;
    localparam logic [2:0] CLS_MOV_IMM = 3'd1;
    localparam logic [2:0] CLS_MOV_REG = 3'd2;
    localparam logic [2:0] CLS_ADD     = 3'd3;
    localparam logic [2:0] CLS_CMP     = 3'd4;
    localparam logic [2:0] CLS_AND     = 3'd5;
    localparam logic [2:0] CLS_MVN     = 3'd6;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the instruction register: instruction class,
// register index fields, shift field and the sign-extended 8-bit immediate.
module instr_decoder
    import instruction_controller_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [15:0]      ir,
    output logic [2:0]       cls,
    output logic [2:0]       rn,
    output logic [2:0]       rd,
    output logic [2:0]       rm,
    output logic [1:0]       sh,
    output logic [WIDTH-1:0] sximm8
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

    always_comb begin
        cls = CLS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM) begin
                cls = CLS_MOV_IMM;
            end else if (op == OP_MOV_REG) begin
                cls = CLS_MOV_REG;
            end else begin
                cls = CLS_ILLEGAL;
            end
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                OP_MVN:  cls = CLS_MVN;
                default: cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/instruction_controller.sv
// Multi-cycle controller: accepts one instruction into IR, then sequences
// register reads, the ALU step and the register write for the datapath.
module instruction_controller
    import instruction_controller_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             done,
    output logic             illegal,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic             loadc,
    output logic             loads,
    output logic             vsel,
    output logic             write,
    output logic [WIDTH-1:0] datapath_in
);

    // Handshake: instr_ready is high only in WAIT and depends on state alone;
    // an edge with instr_valid && instr_ready transfers instr into IR, and IR
    // then holds until the next such edge whatever instr does meanwhile.

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;
    logic [2:0]  cls;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic        accept;

    assign accept = instr_valid && instr_ready;

    instr_decoder #(
        .WIDTH (WIDTH)
    ) u_decoder (
        .ir     (ir),
        .cls    (cls),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm8 (datapath_in)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_WAIT;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                ir <= instr;
            end
        end
    end

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        readnum     = 3'd0;
        writenum    = 3'd0;
        loada       = 1'b0;
        loadb       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        shift       = 2'b00;
        ALUop       = ALU_ADD;
        loadc       = 1'b0;
        loads       = 1'b0;
        vsel        = 1'b0;
        write       = 1'b0;

        case (state)
            ST_WAIT: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    next_state = ST_DECODE;
                end
            end

            ST_DECODE: begin
                case (cls)
                    CLS_MOV_IMM: next_state = ST_WRITE_IMM;
                    CLS_MOV_REG: next_state = ST_GET_B;
                    CLS_MVN:     next_state = ST_GET_B;
                    CLS_ADD:     next_state = ST_GET_A;
                    CLS_CMP:     next_state = ST_GET_A;
                    CLS_AND:     next_state = ST_GET_A;
                    default: begin
                        illegal    = 1'b1;
                        next_state = ST_WAIT;
                    end
                endcase
            end

            ST_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = ST_GET_B;
            end

            ST_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = ST_ALU;
            end

            ST_ALU: begin
                shift = sh;
                // MOV reg and MVN pass B through, so A is forced to zero.
                asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                case (cls)
                    CLS_CMP: ALUop = ALU_SUB;
                    CLS_AND: ALUop = ALU_AND;
                    CLS_MVN: ALUop = ALU_NOT;
                    default: ALUop = ALU_ADD;
                endcase
                if (cls == CLS_CMP) begin
                    loads      = 1'b1;
                    done       = 1'b1;
                    next_state = ST_WAIT;
                end else begin
                    loadc      = 1'b1;
                    next_state = ST_WRITE_REG;
                end
            end

            ST_WRITE_REG: begin
                writenum   = rd;
                write      = 1'b1;
                done       = 1'b1;
                next_state = ST_WAIT;
            end

            ST_WRITE_IMM: begin
                writenum   = rn;
                vsel       = 1'b1;
                write      = 1'b1;
                done       = 1'b1;
                next_state = ST_WAIT;
            end

            default: begin
                next_state = ST_WAIT;
            end
        endcase
    end

endmodule
